fragment_writer: RTL and testbench

Fragment sink for the Celery3D pixel back end. Consumes the `fragment_t` stream produced by the rasterizer through a valid/ready handshake. Optionally depth-tests each fragment against an external Z-buffer, then writes passing fragments to the colour framebuffer port. Also provides a Z-buffer clear sequencer, pass/kill statistics and a busy flag for frame-level control.

---
 rtl/fragment_writer.sv | 205 ++++++++++++++++++++
 tb/tb_fragment_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fragment_writer.sv
// fragment_writer: fragment sink for the Celery3D pixel back end.
// Takes rasterizer fragments over valid/ready, optionally depth-tests them
// against an external Z-buffer, and writes survivors to the colour framebuffer.
// Optional feature macro: CELERY_DEPTH_TEST_EN (depth test + Z-buffer clear).
// With the macro undefined the Z-buffer port is tied off and fragments go
// straight from IDLE to WRITE.

package celery_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] color;
    } fragment_t;
endpackage

module fragment_writer #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19,
    parameter int Z_W       = 16,
    parameter int COLOR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  celery_pkg::fragment_t frag_in,
    input  logic                  frag_valid,
    output logic                  frag_ready,
    input  logic                  clear_start,
    output logic                  clear_done,
    output logic                  zb_re,
    output logic                  zb_we,
    output logic [ADDR_W-1:0]     zb_addr,
    output logic [Z_W-1:0]        zb_wdata,
    input  logic [Z_W-1:0]        zb_rdata,
    output logic                  fb_we,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic [COLOR_W-1:0]    fb_wdata,
    input  logic                  fb_ready,
    output logic [31:0]           pass_count,
    output logic [31:0]           kill_count,
    output logic                  busy
);

    localparam logic [31:0] FB_W32 = 32'(FB_WIDTH);
    localparam logic [31:0] FB_H32 = 32'(FB_HEIGHT);

    typedef enum logic [2:0] {IDLE, READ_Z, TEST, WRITE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_r;
    logic [COLOR_W-1:0]  color_r;
    logic [ADDR_W-1:0]   addr_calc;
    logic                oob;
    logic                accept;
    logic                kill;
    logic                pass;

    assign oob       = ({16'd0, frag_in.x} >= FB_W32) || ({16'd0, frag_in.y} >= FB_H32);
    assign addr_calc = ADDR_W'(frag_in.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(frag_in.x);
    assign busy      = (state != IDLE);

`ifdef CELERY_DEPTH_TEST_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    logic [Z_W-1:0]    z_r;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_fin;
`else
    // Depth inputs have no consumer in this build.
    logic unused_depth;
    assign unused_depth = ^{zb_rdata, clear_start, frag_in.z};
`endif

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and all port drives; every enable defaults low, data to 0.
    always_comb begin
        state_nxt  = state;
        frag_ready = 1'b0;
        clear_done = 1'b0;
        zb_re      = 1'b0;
        zb_we      = 1'b0;
        zb_addr    = '0;
        zb_wdata   = '0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_wdata   = '0;
        accept     = 1'b0;
        kill       = 1'b0;
        pass       = 1'b0;
        case (state)
            IDLE: begin
`ifdef CELERY_DEPTH_TEST_EN
                // A clear request wins over a fragment offered the same cycle.
                frag_ready = !clear_start;
                if (clear_start) begin
                    state_nxt = CLEAR;
                end else if (frag_valid) begin
                    accept = 1'b1;
                    if (oob) kill = 1'b1;
                    else     state_nxt = READ_Z;
                end
`else
                frag_ready = 1'b1;
                if (frag_valid) begin
                    accept = 1'b1;
                    if (oob) kill = 1'b1;
                    else     state_nxt = WRITE;
                end
`endif
            end
`ifdef CELERY_DEPTH_TEST_EN
            READ_Z: begin
                zb_re     = 1'b1;
                zb_addr   = addr_r;
                state_nxt = TEST;
            end
            TEST: begin
                // Strict less-than: an equal depth is killed.
                if (z_r < zb_rdata) begin
                    state_nxt = WRITE;
                end else begin
                    kill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (clr_fin) begin
                    clear_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    zb_we    = 1'b1;
                    zb_addr  = clr_addr;
                    zb_wdata = '1;
                end
            end
`endif
            WRITE: begin
                fb_we    = 1'b1;
                fb_addr  = addr_r;
                fb_wdata = color_r;
                if (fb_ready) begin
                    pass      = 1'b1;
                    state_nxt = IDLE;
`ifdef CELERY_DEPTH_TEST_EN
                    zb_we     = 1'b1;
                    zb_addr   = addr_r;
                    zb_wdata  = z_r;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the fragment on accept; held through the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            color_r <= '0;
`ifdef CELERY_DEPTH_TEST_EN
            z_r     <= '0;
`endif
        end else if (accept) begin
            addr_r  <= addr_calc;
            color_r <= frag_in.color[COLOR_W-1:0];
`ifdef CELERY_DEPTH_TEST_EN
            z_r     <= frag_in.z[Z_W-1:0];
`endif
        end
    end

`ifdef CELERY_DEPTH_TEST_EN
    // Clear address walker; clr_fin marks the extra cycle that pulses done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr <= '0;
            clr_fin  <= 1'b0;
        end else if (state == CLEAR) begin
            if (clr_addr == CLR_LAST) clr_fin  <= 1'b1;
            else                      clr_addr <= clr_addr + 1'b1;
        end else begin
            clr_addr <= '0;
            clr_fin  <= 1'b0;
        end
    end
`endif

    // Statistics, updated the cycle after the deciding event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count <= '0;
            kill_count <= '0;
        end else begin
            if (pass) pass_count <= pass_count + 32'd1;
            if (kill) kill_count <= kill_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fragment_writer.sv
// Bench for fragment_writer at FB_WIDTH=4, FB_HEIGHT=2. Covers the build
// selected by CELERY_DEPTH_TEST_EN; a Z-buffer memory model answers reads.
module tb_fragment_writer;
    localparam int AW = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    celery_pkg::fragment_t frag_in;
    logic                  frag_valid, frag_ready;
    logic                  clear_start, clear_done;
    logic                  zb_re, zb_we;
    logic [AW-1:0]         zb_addr;
    logic [15:0]           zb_wdata, zb_rdata;
    logic                  fb_we;
    logic [AW-1:0]         fb_addr;
    logic [15:0]           fb_wdata;
    logic                  fb_ready;
    logic [31:0]           pass_count, kill_count;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] fb_q[$];
    logic [31:0] zb_q[$];
    logic [31:0] zbr_q[$];
    logic [15:0] zmem[8];

    fragment_writer #(.FB_WIDTH(4), .FB_HEIGHT(2), .ADDR_W(AW), .Z_W(16), .COLOR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frag_in(frag_in), .frag_valid(frag_valid),
        .frag_ready(frag_ready), .clear_start(clear_start), .clear_done(clear_done),
        .zb_re(zb_re), .zb_we(zb_we), .zb_addr(zb_addr), .zb_wdata(zb_wdata),
        .zb_rdata(zb_rdata), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_ready(fb_ready), .pass_count(pass_count), .kill_count(kill_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Z-buffer model with one-cycle read latency.
    always @(posedge clk) begin
        if (zb_re) zb_rdata <= zmem[zb_addr];
        if (zb_we) zmem[zb_addr] <= zb_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int a, input logic [15:0] d);
        return (32'(a) << 16) | {16'd0, d};
    endfunction

    // Scoreboard: sample just before each active edge, pop on every access.
    always begin
        @(negedge clk);
        #4;
        if (rst_n) begin
            if (fb_we && fb_ready) begin
                if (fb_q.size() == 0) chk("fb_write_unexpected", 32'(fb_we), 32'd0);
                else chk("fb_write", {13'd0, fb_addr, fb_wdata}, fb_q.pop_front());
            end
            if (zb_we) begin
                if (zb_q.size() == 0) chk("zb_write_unexpected", 32'(zb_we), 32'd0);
                else chk("zb_write", {13'd0, zb_addr, zb_wdata}, zb_q.pop_front());
            end
            if (zb_re) begin
                if (zbr_q.size() == 0) chk("zb_read_unexpected", 32'(zb_re), 32'd0);
                else chk("zb_read", {29'd0, zb_addr}, zbr_q.pop_front());
            end
        end
    end

    // Offer a fragment, wait (bounded) for acceptance, drop valid after the edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [15:0] c);
        @(negedge clk);
        frag_in.x = x; frag_in.y = y; frag_in.z = z; frag_in.color = c;
        frag_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (frag_ready) break;
            @(negedge clk);
        end
        if (!frag_ready) chk("accept_timeout", 32'(frag_ready), 32'd1);
        @(posedge clk);
        #1 frag_valid = 1'b0;
    endtask

    task automatic reset_checks(input string sfx);
        chk({"rst_frag_ready", sfx}, 32'(frag_ready), 32'd1);
        chk({"rst_busy", sfx}, 32'(busy), 32'd0);
        chk({"rst_fb_we", sfx}, 32'(fb_we), 32'd0);
        chk({"rst_zb_we", sfx}, 32'(zb_we), 32'd0);
        chk({"rst_zb_re", sfx}, 32'(zb_re), 32'd0);
        chk({"rst_clear_done", sfx}, 32'(clear_done), 32'd0);
        chk({"rst_pass", sfx}, pass_count, 32'd0);
        chk({"rst_kill", sfx}, kill_count, 32'd0);
        chk({"rst_addr", sfx}, {26'd0, fb_addr, zb_addr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cyc, done_at;
        rst_n = 1'b0; frag_valid = 1'b0; clear_start = 1'b0; fb_ready = 1'b1;
        frag_in = '0;
        repeat (2) @(negedge clk);
        #1 reset_checks("");
        @(negedge clk) rst_n = 1'b1;

`ifdef CELERY_DEPTH_TEST_EN
        // Clear with a fragment offered the same cycle: clear wins.
        @(negedge clk);
        clear_start = 1'b1; frag_valid = 1'b1;
        frag_in.x = 16'd0; frag_in.y = 16'd0; frag_in.z = 16'h0500; frag_in.color = 16'h1234;
        for (int a = 0; a < 8; a++) zb_q.push_back(ent(a, 16'hFFFF));
        #1 chk("clear_gates_ready", 32'(frag_ready), 32'd0);
        @(posedge clk);
        #1 begin clear_start = 1'b0; frag_valid = 1'b0; end
        busy_cyc = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); #1;
            if (busy) busy_cyc++;
            if (clear_done && done_at == 0) done_at = i;
        end
        chk("clear_busy_cycles", 32'(busy_cyc), 32'd9);
        chk("clear_done_cycle", 32'(done_at), 32'd9);
        chk("clear_writes_left", 32'(zb_q.size()), 32'd0);
        chk("clear_no_accept", pass_count + kill_count, 32'd0);

        // Passing fragment at the last pixel.
        zbr_q.push_back(32'd7); fb_q.push_back(ent(7, 16'hF800)); zb_q.push_back(ent(7, 16'h1000));
        send(16'd3, 16'd1, 16'h1000, 16'hF800);
        @(negedge clk); #1 chk("pass_zb_re_t1", 32'(zb_re), 32'd1);
        @(negedge clk); #1 chk("pass_fb_we_t2", 32'(fb_we), 32'd0);
        @(negedge clk); #1 chk("pass_fb_we_t3", 32'(fb_we), 32'd1);
        @(negedge clk); #1 chk("pass_ready_back", 32'(frag_ready), 32'd1);
        chk("pass_count_1", pass_count, 32'd1);

        // Depth kills: farther, then equal.
        zbr_q.push_back(32'd7);
        send(16'd3, 16'd1, 16'h2000, 16'h0001);
        repeat (3) @(negedge clk);
        zbr_q.push_back(32'd7);
        send(16'd3, 16'd1, 16'h1000, 16'h0002);
        repeat (3) @(negedge clk);
        #1 chk("kill_count_2", kill_count, 32'd2);
        chk("kill_pass_same", pass_count, 32'd1);

        // Backpressure on the colour port.
        fb_ready = 1'b0;
        zbr_q.push_back(32'd2); fb_q.push_back(ent(2, 16'h001F)); zb_q.push_back(ent(2, 16'h0100));
        send(16'd2, 16'd0, 16'h0100, 16'h001F);
        repeat (2) @(negedge clk);
`else
        // clear_start is ignored in this build.
        @(negedge clk);
        clear_start = 1'b1;
        #1 chk("clear_ign_ready", 32'(frag_ready), 32'd1);
        @(posedge clk);
        #1 clear_start = 1'b0;
        busy_cyc = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); #1;
            if (busy) busy_cyc++;
            if (clear_done && done_at == 0) done_at = i;
        end
        chk("clear_ign_busy", 32'(busy_cyc), 32'd0);
        chk("clear_ign_done", 32'(done_at), 32'd0);

        // Direct write, one cycle after accept.
        fb_q.push_back(ent(0, 16'h07E0));
        send(16'd0, 16'd0, 16'h0000, 16'h07E0);
        @(negedge clk); #1;
        chk("nd_fb_we_t1", 32'(fb_we), 32'd1);
        chk("nd_fb_addr", 32'(fb_addr), 32'd0);
        chk("nd_fb_wdata", 32'(fb_wdata), 32'h07E0);
        chk("nd_zb_tied", {14'd0, zb_re, zb_we, zb_wdata}, 32'd0);
        @(negedge clk); #1 chk("nd_ready_back", 32'(frag_ready), 32'd1);
        chk("nd_pass_1", pass_count, 32'd1);

        // Backpressure on the colour port.
        fb_ready = 1'b0;
        fb_q.push_back(ent(2, 16'h001F));
        send(16'd2, 16'd0, 16'h0100, 16'h001F);
`endif
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk); #1;
            chk("bp_fb_we", 32'(fb_we), 32'd1);
            chk("bp_fb_addr", 32'(fb_addr), 32'd2);
            chk("bp_fb_wdata", 32'(fb_wdata), 32'h001F);
            chk("bp_frag_ready", 32'(frag_ready), 32'd0);
            if (i < 5) chk("bp_no_zb_we", 32'(zb_we), 32'd0);
            else begin
                fb_ready = 1'b1;
`ifdef CELERY_DEPTH_TEST_EN
                #1 chk("bp_zb_we", 32'(zb_we), 32'd1);
`else
                #1 chk("bp_zb_we_tied", 32'(zb_we), 32'd0);
`endif
            end
        end
        @(negedge clk); #1 chk("bp_ready_back", 32'(frag_ready), 32'd1);
        chk("bp_pass_2", pass_count, 32'd2);

        // Out-of-bounds fragments: killed next cycle, no memory access.
        send(16'd4, 16'd0, 16'h0000, 16'hAAAA);
        @(negedge clk); #1;
        chk("oob_x_kill", kill_count, 32'(n_kill_base() + 1));
        chk("oob_busy", 32'(busy), 32'd0);
        chk("oob_ready", 32'(frag_ready), 32'd1);
        send(16'd0, 16'd2, 16'h0000, 16'h5555);
        @(negedge clk); #1 chk("oob_y_kill", kill_count, 32'(n_kill_base() + 2));
        chk("oob_pass_same", pass_count, 32'd2);

        repeat (2) @(negedge clk);
        chk("q_fb_empty", 32'(fb_q.size()), 32'd0);
        chk("q_zb_empty", 32'(zb_q.size()), 32'd0);
        chk("q_zbr_empty", 32'(zbr_q.size()), 32'd0);

        // Reset during a stalled write aborts it.
        fb_ready = 1'b0;
`ifdef CELERY_DEPTH_TEST_EN
        zbr_q.push_back(32'd5);
        send(16'd1, 16'd1, 16'h0300, 16'h0F0F);
        repeat (3) @(negedge clk);
`else
        send(16'd1, 16'd1, 16'h0300, 16'h0F0F);
        @(negedge clk);
`endif
        #1 chk("abort_fb_we_pre", 32'(fb_we), 32'd1);
        rst_n = 1'b0;
        #1 reset_checks("_abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1; fb_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("abort_no_write", 32'(fb_q.size() + zb_q.size() + zbr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Kills recorded before the out-of-bounds step in each build.
    function automatic int n_kill_base();
`ifdef CELERY_DEPTH_TEST_EN
        return 2;
`else
        return 0;
`endif
    endfunction

endmodule
